// File: rtl/uart_adder_ctrl.sv
// Collects two 64-bit little-endian operands over UART, adds them externally and returns 9 result bytes.
// First tx_start_o two cycles after the last operand byte; rx bytes arriving while busy are dropped (overrun_o).
module uart_adder_ctrl #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_start_o,
  input  logic        tx_busy_i,
  output logic [63:0] add_a_o,
  output logic [63:0] add_b_o,
  output logic        add_cin_o,
  input  logic [63:0] add_s_i,
  input  logic        add_cout_i,
  output logic        busy_o,
  output logic        overrun_o,
  output logic        timeout_o
);

  typedef enum logic [2:0] {RX_A, RX_B, CALC, TX_SEND, TX_HOLD} state_t;

  localparam logic [23:0] TO_LAST = 24'(TIMEOUT_CYC - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [23:0] r_to_cnt, w_to_nxt;
  logic [63:0] r_a, r_b;
  logic [64:0] r_res;
  logic [7:0]  r_tx_last;
  logic        r_overrun, r_timeout;
  logic        w_wr_a, w_wr_b, w_load_res, w_tx_fire, w_to_fire, w_drop, w_to_armed;
  logic [71:0] w_res_ext;
  logic [7:0]  w_tx_byte;

  assign w_res_ext  = {7'b0, r_res};
  assign w_tx_byte  = w_res_ext[{r_cnt, 3'b000} +: 8];
  // Idle in RX_A with nothing received yet never times out.
  assign w_to_armed = (r_state == RX_B) || ((r_state == RX_A) && (r_cnt != 4'd0));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= RX_A;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_to_nxt    = '0;
    w_wr_a      = 1'b0;
    w_wr_b      = 1'b0;
    w_load_res  = 1'b0;
    w_tx_fire   = 1'b0;
    w_to_fire   = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      RX_A, RX_B: begin
        if (rx_valid_i) begin
          w_wr_a = (r_state == RX_A);
          w_wr_b = (r_state == RX_B);
          if (r_cnt == 4'd7) begin
            w_cnt_nxt   = 4'd0;
            w_state_nxt = (r_state == RX_A) ? RX_B : CALC;
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end else if (w_to_armed) begin
          if (r_to_cnt == TO_LAST) begin
            w_to_fire   = 1'b1;
            w_cnt_nxt   = 4'd0;
            w_state_nxt = RX_A;
          end else begin
            w_to_nxt = r_to_cnt + 24'd1;
          end
        end
      end
      CALC: begin
        w_drop      = rx_valid_i;
        w_load_res  = 1'b1;
        w_cnt_nxt   = 4'd0;
        w_state_nxt = TX_SEND;
      end
      TX_SEND: begin
        w_drop = rx_valid_i;
        if (!tx_busy_i) begin
          w_tx_fire   = 1'b1;
          w_state_nxt = TX_HOLD;
        end
      end
      TX_HOLD: begin
        w_drop = rx_valid_i;
        if (r_cnt == 4'd8) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = RX_A;
        end else begin
          w_cnt_nxt   = r_cnt + 4'd1;
          w_state_nxt = TX_SEND;
        end
      end
      default: begin
        w_cnt_nxt   = 4'd0;
        w_state_nxt = RX_A;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt     <= 4'd0;
      r_to_cnt  <= 24'd0;
      r_a       <= 64'd0;
      r_b       <= 64'd0;
      r_res     <= 65'd0;
      r_tx_last <= 8'd0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_to_cnt  <= w_to_nxt;
      r_overrun <= w_drop;
      r_timeout <= w_to_fire;
      if (w_wr_a)     r_a[{r_cnt[2:0], 3'b000} +: 8] <= rx_data_i;
      if (w_wr_b)     r_b[{r_cnt[2:0], 3'b000} +: 8] <= rx_data_i;
      if (w_load_res) r_res <= {add_cout_i, add_s_i};
      if (w_tx_fire)  r_tx_last <= w_tx_byte;
    end
  end

  // The strobe cycle shows the live byte; afterwards the captured copy holds.
  assign tx_start_o = w_tx_fire;
  assign tx_data_o  = w_tx_fire ? w_tx_byte : r_tx_last;
  assign add_a_o    = r_a;
  assign add_b_o    = r_b;
  assign add_cin_o  = 1'b0;
  assign busy_o     = (r_state == CALC) || (r_state == TX_SEND) || (r_state == TX_HOLD);
  assign overrun_o  = r_overrun;
  assign timeout_o  = r_timeout;

endmodule

// File: tb/tb_uart_adder_ctrl.sv
// Directed bench for uart_adder_ctrl: operand frames, carry byte, timeout, overrun and mid-frame reset.
module tb_uart_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic [7:0]  rx_data_i = 8'd0;
  logic        rx_valid_i = 1'b0;
  logic [7:0]  tx_data_o;
  logic        tx_start_o;
  logic        tx_busy_i;
  logic [63:0] add_a_o, add_b_o, add_s_i;
  logic        add_cin_o, add_cout_i, busy_o, overrun_o, timeout_o;

  always #5 clk = ~clk;

  uart_adder_ctrl #(.TIMEOUT_CYC(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .tx_data_o(tx_data_o), .tx_start_o(tx_start_o), .tx_busy_i(tx_busy_i),
    .add_a_o(add_a_o), .add_b_o(add_b_o), .add_cin_o(add_cin_o),
    .add_s_i(add_s_i), .add_cout_i(add_cout_i), .busy_o(busy_o),
    .overrun_o(overrun_o), .timeout_o(timeout_o)
  );

  assign {add_cout_i, add_s_i} = {1'b0, add_a_o} + {1'b0, add_b_o} + {64'd0, add_cin_o};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // UART transmitter model: busy for busy_len cycles after each start, plus a forced-busy override.
  int   busy_len = 0;
  int   mb_cnt = 0;
  logic force_busy = 1'b0;
  always @(posedge clk) begin
    if (tx_start_o && busy_len > 0) mb_cnt <= busy_len;
    else if (mb_cnt > 0)            mb_cnt <= mb_cnt - 1;
  end
  assign tx_busy_i = force_busy | (mb_cnt != 0);

  logic [7:0] txq[$];
  int         txcyc[$];
  int         n_ovr = 0, n_to = 0, n_bad = 0;
  always @(negedge clk) begin
    if (tx_start_o) begin
      txq.push_back(tx_data_o);
      txcyc.push_back(cyc);
      if (tx_busy_i) n_bad++;
    end
    if (overrun_o) n_ovr++;
    if (timeout_o) n_to++;
  end

  int n_vec = 0, n_err = 0;
  int last_strobe = 0;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    idle(1);
    rx_valid_i  = 1'b0;
    last_strobe = cyc;
  endtask

  task automatic send_frame(input logic [63:0] a, input logic [63:0] b);
    for (int i = 0; i < 8; i++) send_byte(a[i*8 +: 8]);
    for (int i = 0; i < 8; i++) send_byte(b[i*8 +: 8]);
  endtask

  task automatic wait_tx(input string tag, input int n);
    for (int k = 0; k < 400 && txq.size() < n; k++) idle(1);
    chk(tag, 72'(txq.size()), 72'(n));
  endtask

  task automatic check_tx(input string tag, input logic [71:0] exp);
    logic [7:0] obs;
    for (int i = 0; i < 9; i++) begin
      obs = (i < txq.size()) ? txq[i] : 8'hxx;
      chk($sformatf("%s_byte%0d", tag, i), {64'd0, obs}, {64'd0, exp[i*8 +: 8]});
    end
  endtask

  initial begin
    // Reset state
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_tx_start", 72'(tx_start_o), 72'd0);
    chk("rst_tx_data",  72'(tx_data_o),  72'd0);
    chk("rst_busy",     72'(busy_o),     72'd0);
    chk("rst_flags",    72'({overrun_o, timeout_o}), 72'd0);
    chk("rst_ops",      {8'd0, add_a_o | add_b_o}, 72'd0);
    chk("rst_cin",      72'(add_cin_o),  72'd0);
    idle(2);
    rst_ni = 1'b1;
    idle(2);

    // 1 + 1, no busy: latency and byte stream
    busy_len = 0;
    txq.delete(); txcyc.delete();
    send_frame(64'd1, 64'd1);
    chk("t1_busy_calc", 72'(busy_o), 72'd1);
    chk("t1_add_a", {8'd0, add_a_o}, 72'd1);
    chk("t1_add_b", {8'd0, add_b_o}, 72'd1);
    wait_tx("t1_count", 9);
    chk("t1_latency", 72'((txcyc.size() > 0) ? txcyc[0] : -1), 72'(last_strobe + 1));
    check_tx("t1", {8'h00, 64'd2});
    idle(3);
    chk("t1_idle_busy", 72'(busy_o), 72'd0);

    // All-ones + 1: carry byte, with transmitter busy between bytes
    busy_len = 3;
    txq.delete(); txcyc.delete();
    send_frame(64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    wait_tx("t2_count", 9);
    check_tx("t2", {8'h01, 64'd0});
    idle(8);
    chk("t2_tx_data_hold", 72'(tx_data_o), 72'h01);
    chk("t2_no_start_busy", 72'(n_bad), 72'd0);

    // Timeout: a byte on the expiry cycle wins, then a real expiry
    txq.delete(); txcyc.delete();
    send_byte(8'hAA); send_byte(8'hBB);
    idle(15);
    send_byte(8'hCC);
    idle(1);
    chk("t3_byte_wins", 72'(n_to), 72'd0);
    send_byte(8'hDD);
    send_byte(8'hEE);
    idle(15);
    chk("t3_before_expiry", 72'(timeout_o), 72'd0);
    idle(1);
    chk("t3_expiry_pulse", 72'(timeout_o), 72'd1);
    idle(1);
    chk("t3_pulse_width", 72'(timeout_o), 72'd0);
    idle(40);
    chk("t3_idle_no_timeout", 72'(n_to), 72'd1);
    send_frame(64'd3, 64'd4);
    wait_tx("t3_count", 9);
    check_tx("t3", {8'h00, 64'd7});
    idle(12);

    // Overrun while waiting on a busy transmitter
    busy_len = 2;
    force_busy = 1'b1;
    txq.delete(); txcyc.delete();
    send_frame(64'd5, 64'd6);
    idle(1);
    send_byte(8'h5A);
    chk("t4_overrun_pulse", 72'(overrun_o), 72'd1);
    idle(1);
    chk("t4_overrun_width", 72'(overrun_o), 72'd0);
    idle(45);
    chk("t4_no_start", 72'(txq.size()), 72'd0);
    chk("t4_ops_kept", {add_a_o[7:0], add_b_o}, {8'd5, 64'd6});
    chk("t4_overrun_count", 72'(n_ovr), 72'd1);
    force_busy = 1'b0;
    wait_tx("t4_count", 9);
    check_tx("t4", {8'h00, 64'd11});
    chk("t4_no_start_busy", 72'(n_bad), 72'd0);
    idle(12);

    // Reset mid operand B
    busy_len = 0;
    txq.delete(); txcyc.delete();
    for (int i = 0; i < 8; i++) send_byte(8'h11);
    for (int i = 0; i < 3; i++) send_byte(8'h22);
    rst_ni = 1'b0;
    #1;
    chk("t5_rst_ops", {8'd0, add_a_o | add_b_o}, 72'd0);
    chk("t5_rst_outs", 72'({busy_o, tx_start_o, overrun_o, timeout_o, tx_data_o}), 72'd0);
    idle(1);
    rst_ni = 1'b1;
    idle(1);
    send_frame(64'd2, 64'd5);
    wait_tx("t5_count", 9);
    check_tx("t5", {8'h00, 64'd7});
    chk("t5_no_extra_timeout", 72'(n_to), 72'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
